// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop input synchroniser, mid-bit sampling, start-glitch
// rejection, framing-error detection and a one-cycle valid strobe per good byte.
module uart_rx #(
    parameter int unsigned CLKS_PER_BIT = 12
) (
    input  logic       i_Clock,
    input  logic       i_Reset,
    input  logic       i_Rx_Serial,
    output logic       o_Rx_DV,
    output logic [7:0] o_Rx_Byte,
    output logic       o_Rx_Frame_Err,
    output logic       o_Rx_Active
);

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] START     = 3'd1;
    localparam logic [2:0] DATA      = 3'd2;
    localparam logic [2:0] STOP      = 3'd3;
    localparam logic [2:0] CLEANUP   = 3'd4;
    localparam logic [2:0] WAIT_HIGH = 3'd5;

    localparam logic [7:0] HALF = 8'((CLKS_PER_BIT - 1) / 2);
    localparam logic [7:0] LAST = 8'(CLKS_PER_BIT - 1);

    logic [2:0] state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [2:0] idx_q, idx_d;
    logic [7:0] shift_q, shift_d;
    logic [7:0] byte_q, byte_d;
    logic       dv_q, dv_d;
    logic       ferr_q, ferr_d;
    logic       active_q, active_d;
    logic       sync1_q;
    logic       rx_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        byte_d  = byte_q;
        dv_d    = 1'b0;
        ferr_d  = 1'b0;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                idx_d = '0;
                if (!rx_q) begin
                    state_d = START;
                end
            end
            START: begin
                // Re-check the line half a bit in; a high here was only a glitch.
                if (cnt_q == HALF) begin
                    cnt_d   = '0;
                    state_d = rx_q ? IDLE : DATA;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            DATA: begin
                if (cnt_q == LAST) begin
                    cnt_d          = '0;
                    shift_d[idx_q] = rx_q;
                    if (idx_q == 3'd7) begin
                        idx_d   = '0;
                        state_d = STOP;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            STOP: begin
                if (cnt_q == LAST) begin
                    cnt_d = '0;
                    if (rx_q) begin
                        byte_d  = shift_q;
                        dv_d    = 1'b1;
                        state_d = CLEANUP;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = WAIT_HIGH;
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            CLEANUP: begin
                state_d = IDLE;
            end
            WAIT_HIGH: begin
                if (rx_q) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        active_d = (state_d != IDLE);
    end

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            idx_q    <= '0;
            shift_q  <= '0;
            byte_q   <= '0;
            dv_q     <= 1'b0;
            ferr_q   <= 1'b0;
            active_q <= 1'b0;
            sync1_q  <= 1'b1;
            rx_q     <= 1'b1;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            shift_q  <= shift_d;
            byte_q   <= byte_d;
            dv_q     <= dv_d;
            ferr_q   <= ferr_d;
            active_q <= active_d;
            sync1_q  <= i_Rx_Serial;
            rx_q     <= sync1_q;
        end
    end

    assign o_Rx_DV        = dv_q;
    assign o_Rx_Byte      = byte_q;
    assign o_Rx_Frame_Err = ferr_q;
    assign o_Rx_Active    = active_q;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: a TX model drives the line, and the expected outcome of each
// frame is predicted by sampling the driven waveform at the nominal mid-bit instants.
module tb_uart_rx;

    localparam int unsigned CPB   = 12;
    localparam int unsigned HALF  = (CPB - 1) / 2;
    localparam int unsigned SAMP0 = HALF + 1;
    localparam int unsigned LAT   = 2 + HALF + 1 + 9 * CPB + 1;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx  = 1'b1;
    logic       dv;
    logic [7:0] rbyte;
    logic       ferr;
    logic       active;

    uart_rx #(.CLKS_PER_BIT(CPB)) dut (
        .i_Clock        (clk),
        .i_Reset        (rst),
        .i_Rx_Serial    (rx),
        .o_Rx_DV        (dv),
        .o_Rx_Byte      (rbyte),
        .o_Rx_Frame_Err (ferr),
        .o_Rx_Active    (active)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc++;

    int unsigned errors = 0;
    int unsigned checks = 0;

    logic [7:0]  dv_bytes[$];
    int unsigned dv_cycs[$];
    int unsigned ferr_n = 0;
    int unsigned both_n = 0;
    int unsigned long_n = 0;
    logic        dv_prev = 1'b0;

    always @(negedge clk) begin
        if (dv === 1'b1) begin
            dv_bytes.push_back(rbyte);
            dv_cycs.push_back(cyc);
            if (dv_prev) long_n++;
        end
        if (ferr === 1'b1) ferr_n++;
        if (dv === 1'b1 && ferr === 1'b1) both_n++;
        dv_prev = (dv === 1'b1);
    end

    logic wave [0:511];
    logic [7:0] model_byte = 8'h00;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int unsigned n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Caller is aligned just after a rising edge; t0 is that edge's index.
    task automatic send_frame(input logic [7:0] b, input int unsigned per,
                              input int unsigned stop_low, output int unsigned t0);
        int unsigned t;
        logic [9:0] slots;
        slots = {1'b1, b, 1'b0};
        for (int i = 0; i < 512; i++) wave[i] = 1'b1;
        t0 = cyc;
        t  = 0;
        for (int s = 0; s < 10; s++) begin
            if (s == 9) begin
                for (int k = 0; k < int'(stop_low); k++) begin
                    rx = 1'b0; wave[t] = 1'b0; t++; tick(1);
                end
            end
            for (int k = 0; k < int'(per); k++) begin
                rx = slots[s]; wave[t] = slots[s]; t++; tick(1);
            end
        end
    endtask

    function automatic void predict(output logic pdv, output logic pfe, output logic [7:0] pb);
        pdv = 1'b0;
        pfe = 1'b0;
        pb  = 8'h00;
        if (wave[SAMP0] == 1'b0) begin
            for (int j = 0; j < 8; j++) pb[j] = wave[SAMP0 + (j + 1) * CPB];
            if (wave[SAMP0 + 9 * CPB]) pdv = 1'b1;
            else                       pfe = 1'b1;
        end
    endfunction

    task automatic wait_done(input int unsigned t0);
        int unsigned n;
        n = 0;
        while ((cyc < t0 + LAT + 8 || active !== 1'b0) && n < 600) begin
            tick(1);
            n++;
        end
        check("idle_timeout", 32'(n < 600), 32'd1);
    endtask

    task automatic frame_check(input string tag, input logic [7:0] b, input int unsigned per,
                               input int unsigned stop_low, input int unsigned probe);
        int unsigned t0, n0, f0;
        logic pdv, pfe;
        logic [7:0] pb;
        n0 = dv_bytes.size();
        f0 = ferr_n;
        fork
            send_frame(b, per, stop_low, t0);
            begin
                if (probe != 0) begin
                    tick(probe);
                    check({tag, "_active_hold"}, 32'(active), 32'd1);
                end
            end
        join
        predict(pdv, pfe, pb);
        wait_done(t0);
        check({tag, "_dv_count"}, 32'(dv_bytes.size() - n0), 32'(pdv));
        check({tag, "_ferr_count"}, ferr_n - f0, 32'(pfe));
        if (pdv && dv_bytes.size() > n0) begin
            check({tag, "_byte"}, 32'(dv_bytes[n0]), 32'(pb));
            check({tag, "_latency"}, dv_cycs[n0] - t0, LAT);
            model_byte = pb;
        end
        check({tag, "_held_byte"}, 32'(rbyte), 32'(model_byte));
        check({tag, "_active_end"}, 32'(active), 32'd0);
    endtask

    int unsigned ta, tb2, n0, f0;
    logic d1, e1, d2, e2;
    logic [7:0] b1, b2;

    initial begin
        tick(3);
        check("rst_dv", 32'(dv), 32'd0);
        check("rst_byte", 32'(rbyte), 32'd0);
        check("rst_ferr", 32'(ferr), 32'd0);
        check("rst_active", 32'(active), 32'd0);
        rst = 1'b0;
        tick(5);

        frame_check("a5", 8'hA5, CPB, 0, 0);

        // Back-to-back frames with no idle gap.
        n0 = dv_bytes.size();
        f0 = ferr_n;
        send_frame(8'h00, CPB, 0, ta);
        predict(d1, e1, b1);
        send_frame(8'hFF, CPB, 0, tb2);
        predict(d2, e2, b2);
        wait_done(tb2);
        check("b2b_dv_count", 32'(dv_bytes.size() - n0), 32'(d1) + 32'(d2));
        check("b2b_ferr_count", ferr_n - f0, 32'(e1) + 32'(e2));
        if (dv_bytes.size() >= n0 + 2) begin
            check("b2b_byte0", 32'(dv_bytes[n0]), 32'(b1));
            check("b2b_byte1", 32'(dv_bytes[n0 + 1]), 32'(b2));
            check("b2b_latency0", dv_cycs[n0] - ta, LAT);
            check("b2b_latency1", dv_cycs[n0 + 1] - tb2, LAT);
        end
        model_byte = b2;

        // Start-bit glitch: 3 low clocks must not start a frame.
        n0 = dv_bytes.size();
        f0 = ferr_n;
        rx = 1'b0;
        tick(3);
        check("glitch_active_rise", 32'(active), 32'd1);
        rx = 1'b1;
        tick(6);
        check("glitch_active_drop", 32'(active), 32'd0);
        tick(20);
        check("glitch_dv_count", 32'(dv_bytes.size() - n0), 32'd0);
        check("glitch_ferr_count", ferr_n - f0, 32'd0);

        // Stop bit held low for 30 clocks, then a good frame.
        frame_check("ferr55", 8'h55, CPB, 30, 136);
        tick(4);
        frame_check("after_ferr3c", 8'h3C, CPB, 0, 0);

        // Reset pulse during data bit 4.
        n0 = dv_bytes.size();
        f0 = ferr_n;
        fork
            send_frame(8'hF0, CPB, 0, ta);
            begin
                tick(66);
                rst = 1'b1;
                tick(1);
                check("midrst_dv", 32'(dv), 32'd0);
                check("midrst_byte", 32'(rbyte), 32'd0);
                check("midrst_ferr", 32'(ferr), 32'd0);
                check("midrst_active", 32'(active), 32'd0);
                rst = 1'b0;
            end
        join
        model_byte = 8'h00;
        tick(20);
        check("midrst_no_dv", 32'(dv_bytes.size() - n0), 32'd0);
        check("midrst_no_ferr", ferr_n - f0, 32'd0);
        frame_check("after_rst81", 8'h81, CPB, 0, 0);

        // Off-nominal bit periods; outcome follows the mid-bit sample instants.
        frame_check("p11_96", 8'h96, 11, 0, 0);
        tick(4);
        frame_check("p13_96", 8'h96, 13, 0, 0);
        tick(4);

        for (int i = 0; i < 6; i++) begin
            frame_check("rand", 8'($urandom), CPB, 0, 0);
            tick($urandom_range(0, 7));
        end

        check("dv_ferr_overlap", both_n, 32'd0);
        check("dv_pulse_width", long_n, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
